// File: rtl/seg7_pkg.sv
// Shared constants for the BCD scan counter: digit width and active-low
// segment patterns in {g,f,e,d,c,b,a} order.
package seg7_pkg;

    localparam int BCD_W = 4;

    typedef logic [BCD_W-1:0] bcd_digit_t;

    localparam logic [6:0] SEG_BLANK = 7'b1111111;

    // Indexed directly by a 4-bit digit; codes 10-15 map to blank.
    localparam logic [15:0][6:0] SEG_PAT = {
        {6{SEG_BLANK}},
        7'b0010000,  // 9
        7'b0000000,  // 8
        7'b1111000,  // 7
        7'b0000010,  // 6
        7'b0010010,  // 5
        7'b0011001,  // 4
        7'b0110000,  // 3
        7'b0100100,  // 2
        7'b1111001,  // 1
        7'b1000000   // 0
    };

endpackage

// File: rtl/seg7_dec.sv
// Combinational BCD digit to active-low 7-segment decode; non-decimal codes
// produce a blank digit.
module seg7_dec
    import seg7_pkg::*;
(
    input  logic [BCD_W-1:0] digit,
    output logic [6:0]       seg
);

    always_comb begin
        seg = SEG_PAT[digit];
    end

endmodule

// File: rtl/seg7_scan_counter.sv
// Multi-digit up/down BCD counter with a time-multiplexed active-low
// 7-segment display scanner and optional leading-zero blanking.
module seg7_scan_counter
    import seg7_pkg::*;
#(
    parameter int DIGITS        = 4,
    parameter int SCAN_DIV      = 1000,
    parameter int BLANK_LEADING = 1
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    en,
    input  logic                    up,
    input  logic                    clr,
    input  logic                    load,
    input  logic [BCD_W*DIGITS-1:0] load_val,
    output logic [BCD_W*DIGITS-1:0] bcd,
    output logic                    carry,
    output logic [6:0]              seg,
    output logic [DIGITS-1:0]       an
);

    localparam int CNT_W = BCD_W * DIGITS;
    localparam int IDX_W = (DIGITS > 1) ? $clog2(DIGITS) : 1;
    localparam int PRE_W = $clog2(SCAN_DIV);

    logic [CNT_W-1:0]  inc_val;
    logic [CNT_W-1:0]  dec_val;
    logic [CNT_W-1:0]  load_clean;
    logic              inc_wrap;
    logic              dec_wrap;
    logic [DIGITS-1:0] blank;
    bcd_digit_t        cur_d;
    bcd_digit_t        ld_d;
    logic              inc_c;
    logic              dec_b;
    logic              hi_zero;

    // Ripple the decimal carry/borrow digit by digit from the least significant end.
    always_comb begin
        inc_val    = '0;
        dec_val    = '0;
        load_clean = '0;
        blank      = '0;
        cur_d      = '0;
        ld_d       = '0;
        inc_c      = 1'b1;
        dec_b      = 1'b1;
        for (int i = 0; i < DIGITS; i++) begin
            cur_d = bcd[i*BCD_W +: BCD_W];
            ld_d  = load_val[i*BCD_W +: BCD_W];
            if (!inc_c)
                inc_val[i*BCD_W +: BCD_W] = cur_d;
            else
                inc_val[i*BCD_W +: BCD_W] = (cur_d == 4'd9) ? 4'd0 : cur_d + 4'd1;
            if (!dec_b)
                dec_val[i*BCD_W +: BCD_W] = cur_d;
            else
                dec_val[i*BCD_W +: BCD_W] = (cur_d == 4'd0) ? 4'd9 : cur_d - 4'd1;
            inc_c = inc_c && (cur_d == 4'd9);
            dec_b = dec_b && (cur_d == 4'd0);
            load_clean[i*BCD_W +: BCD_W] = (ld_d > 4'd9) ? 4'd0 : ld_d;
        end
        inc_wrap = inc_c;
        dec_wrap = dec_b;

        hi_zero = 1'b1;
        for (int i = DIGITS - 1; i >= 0; i--) begin
            hi_zero  = hi_zero && (bcd[i*BCD_W +: BCD_W] == 4'd0);
            blank[i] = (BLANK_LEADING != 0) && (i != 0) && hi_zero;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            bcd   <= '0;
            carry <= 1'b0;
        end else begin
            carry <= 1'b0;
            if (clr) begin
                bcd <= '0;
            end else if (load) begin
                bcd <= load_clean;
            end else if (en) begin
                bcd   <= up ? inc_val : dec_val;
                carry <= up ? inc_wrap : dec_wrap;
            end
        end
    end

    logic [PRE_W-1:0] presc;
    logic [IDX_W-1:0] idx;
    logic [IDX_W-1:0] idx_next;
    logic             presc_tc;
    bcd_digit_t       sel_digit;
    logic [6:0]       seg_dec;

    assign presc_tc = (presc == PRE_W'(SCAN_DIV - 1));

    always_comb begin
        idx_next = idx;
        if (presc_tc)
            idx_next = (idx == IDX_W'(DIGITS - 1)) ? '0 : idx + IDX_W'(1);
    end

    // Decode the digit that will be selected next so an and seg switch together.
    always_comb begin
        sel_digit = '0;
        for (int i = 0; i < DIGITS; i++) begin
            if (idx_next == IDX_W'(i))
                sel_digit = blank[i] ? 4'hF : bcd[i*BCD_W +: BCD_W];
        end
    end

    seg7_dec u_dec (
        .digit (sel_digit),
        .seg   (seg_dec)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            presc <= '0;
            idx   <= '0;
            an    <= ~DIGITS'(1);
            seg   <= SEG_PAT[0];
        end else begin
            presc <= presc_tc ? '0 : presc + PRE_W'(1);
            idx   <= idx_next;
            an    <= ~(DIGITS'(1) << idx_next);
            seg   <= seg_dec;
        end
    end

endmodule

// File: tb/tb_seg7_scan_counter.sv
// Scoreboard bench for seg7_scan_counter: the driver queues expected values
// tagged with a cycle number; a negedge monitor pops and compares them.
module tb_seg7_scan_counter;

    localparam int K_BCD   = 0;
    localparam int K_CARRY = 1;
    localparam int K_AN    = 2;
    localparam int K_SEG   = 3;
    localparam int K_SEGB  = 4;
    localparam int K_ANB   = 5;
    localparam int K_BCDB  = 6;
    localparam int K_CARB  = 7;

    localparam logic [6:0] BL = 7'b1111111;
    localparam logic [6:0] S0 = 7'b1000000;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        en, up, clr, load;
    logic [15:0] load_val;
    logic [15:0] bcd_a, bcd_b;
    logic        carry_a, carry_b;
    logic [6:0]  seg_a, seg_b;
    logic [3:0]  an_a, an_b;

    seg7_scan_counter #(.DIGITS(4), .SCAN_DIV(4), .BLANK_LEADING(1)) dut_a (
        .clk(clk), .rst_n(rst_n), .en(en), .up(up), .clr(clr), .load(load),
        .load_val(load_val), .bcd(bcd_a), .carry(carry_a), .seg(seg_a), .an(an_a)
    );

    seg7_scan_counter #(.DIGITS(4), .SCAN_DIV(4), .BLANK_LEADING(0)) dut_b (
        .clk(clk), .rst_n(rst_n), .en(en), .up(up), .clr(clr), .load(load),
        .load_val(load_val), .bcd(bcd_b), .carry(carry_b), .seg(seg_b), .an(an_b)
    );

    always #5 clk = ~clk;

    typedef struct {
        int          cyc;
        int          kind;
        logic [15:0] val;
        string       name;
    } exp_t;

    exp_t q[$];
    int   cyc = 0;
    int   rel = 0;
    int   n_cmp = 0;
    int   n_bad = 0;
    logic done = 1'b0;
    logic final_seen = 1'b0;

    always @(posedge clk) cyc <= cyc + 1;

    function automatic logic [15:0] actual(input int kind);
        case (kind)
            K_BCD:   return bcd_a;
            K_CARRY: return {15'd0, carry_a};
            K_AN:    return {12'd0, an_a};
            K_SEG:   return {9'd0, seg_a};
            K_SEGB:  return {9'd0, seg_b};
            K_ANB:   return {12'd0, an_b};
            K_BCDB:  return bcd_b;
            default: return {15'd0, carry_b};
        endcase
    endfunction

    always @(negedge clk) begin
        exp_t e;
        logic [15:0] act;
        while (q.size() > 0 && q[0].cyc <= cyc) begin
            e = q.pop_front();
            n_cmp++;
            if (e.cyc < cyc) begin
                n_bad++;
                $display("FAIL %s missed: due cycle %0d, now %0d", e.name, e.cyc, cyc);
            end else begin
                act = actual(e.kind);
                if (act !== e.val) begin
                    n_bad++;
                    $display("FAIL %s cyc=%0d got=%h want=%h", e.name, cyc, act, e.val);
                end
            end
        end
        if (done && !final_seen) begin
            final_seen = 1'b1;
            if (q.size() > 0) begin
                n_cmp++;
                n_bad++;
                $display("FAIL drain: %0d expectations never reached, want 0", q.size());
                q.delete();
            end
        end
    end

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input int d, input int k, input logic [15:0] v, input string n);
        exp_t e;
        e.cyc  = cyc + d;
        e.kind = k;
        e.val  = v;
        e.name = n;
        q.push_back(e);
    endtask

    task automatic reset_chk(input string n);
        chk(0, K_BCD,   16'h0000, {n, "_bcd"});
        chk(0, K_CARRY, 16'd0,    {n, "_carry"});
        chk(0, K_AN,    16'hE,    {n, "_an"});
        chk(0, K_SEG,   {9'd0, S0}, {n, "_seg"});
        chk(0, K_ANB,   16'hE,    {n, "_an_b"});
        chk(0, K_SEGB,  {9'd0, S0}, {n, "_seg_b"});
        chk(0, K_BCDB,  16'h0000, {n, "_bcd_b"});
        chk(0, K_CARB,  16'd0,    {n, "_carry_b"});
    endtask

    // Patterns packed {idx3, idx2, idx1, idx0}; index advances every 4 clocks from reset release.
    task automatic push_scan(input int c0, input int n, input logic [27:0] pa,
                             input logic [27:0] pb, input string nm);
        int c, ix;
        for (int j = 0; j < n; j++) begin
            c  = c0 + j;
            ix = ((cyc + c - rel) / 4) % 4;
            chk(c, K_AN,   {12'd0, ~(4'b0001 << ix)}, {nm, "_an"});
            chk(c, K_SEG,  {9'd0, pa[ix*7 +: 7]},     {nm, "_seg"});
            chk(c, K_SEGB, {9'd0, pb[ix*7 +: 7]},     {nm, "_seg_nb"});
            chk(c, K_ANB,  {12'd0, ~(4'b0001 << ix)}, {nm, "_an_b"});
        end
    endtask

    initial begin
        rst_n = 1'b0; en = 1'b0; up = 1'b0; clr = 1'b0; load = 1'b0; load_val = '0;
        tick; tick;
        reset_chk("por");
        tick;
        rst_n = 1'b1;
        rel = cyc;

        chk(1, K_BCD, 16'h0000, "hold_idle");
        tick;

        load = 1'b1; load_val = 16'h1A3F;
        chk(1, K_BCD, 16'h1030, "load_sanitize");
        chk(1, K_CARRY, 16'd0, "load_no_carry");
        tick;
        clr = 1'b1;
        chk(1, K_BCD, 16'h0000, "clr_over_load");
        tick;
        clr = 1'b0; load_val = 16'h0199;
        chk(1, K_BCD, 16'h0199, "load_0199");
        tick;
        load = 1'b0; en = 1'b1; up = 1'b1;
        chk(1, K_BCD, 16'h0200, "inc_ripple");
        chk(1, K_CARRY, 16'd0, "inc_no_wrap");
        tick;
        up = 1'b0;
        chk(1, K_BCD, 16'h0199, "dec_borrow");
        tick;
        load = 1'b1; up = 1'b1; load_val = 16'h0500;
        chk(1, K_BCD, 16'h0500, "load_over_en");
        tick;
        load = 1'b0; en = 1'b0;
        chk(1, K_BCD, 16'h0500, "hold");
        tick;

        load = 1'b1; load_val = 16'h0000;
        chk(1, K_BCD, 16'h0000, "load_zero");
        tick;
        load = 1'b0; en = 1'b1; up = 1'b0;
        chk(1, K_BCD, 16'h9999, "dec_wrap");
        chk(1, K_CARRY, 16'd1, "dec_wrap_carry");
        tick;
        en = 1'b0;
        chk(1, K_CARRY, 16'd0, "dec_carry_one_cycle");
        chk(1, K_BCD, 16'h9999, "hold_9999");
        tick;

        clr = 1'b1;
        chk(1, K_BCD, 16'h0000, "clr");
        chk(1, K_CARRY, 16'd0, "clr_no_carry");
        tick;
        clr = 1'b0; en = 1'b1; up = 1'b1;
        for (int d = 1; d <= 10001; d++) begin
            chk(d, K_CARRY, (d == 10000) ? 16'd1 : 16'd0, "inc_run_carry");
            if (d == 1)     chk(d, K_BCD, 16'h0001, "inc_run_first");
            if (d == 9999)  chk(d, K_BCD, 16'h9999, "inc_run_9999");
            if (d == 10000) chk(d, K_BCD, 16'h0000, "inc_run_wrap");
        end
        repeat (10000) tick;
        en = 1'b0;
        tick;

        load = 1'b1; load_val = 16'h0042;
        tick;
        load = 1'b0;
        push_scan(1, 20, {BL, BL, 7'b0011001, 7'b0100100},
                  {S0, S0, 7'b0011001, 7'b0100100}, "scan_0042");
        repeat (21) tick;

        load = 1'b1; load_val = 16'h0007;
        tick;
        load = 1'b0;
        push_scan(1, 16, {BL, BL, BL, 7'b1111000},
                  {S0, S0, S0, 7'b1111000}, "scan_0007");
        repeat (17) tick;

        load = 1'b1; load_val = 16'h0537;
        tick;
        load = 1'b0;
        push_scan(1, 8, {BL, 7'b0010010, 7'b0110000, 7'b1111000},
                  {S0, 7'b0010010, 7'b0110000, 7'b1111000}, "scan_0537");
        repeat (10) tick;
        #2;
        rst_n = 1'b0;
        reset_chk("async_rst");
        tick; tick;
        rst_n = 1'b1;
        rel = cyc;
        chk(1, K_BCD, 16'h0000, "restart_bcd");
        push_scan(1, 9, {BL, BL, BL, S0}, {S0, S0, S0, S0}, "restart_scan");
        repeat (10) tick;

        for (int k = 0; k < 50 && q.size() > 0; k++) tick;
        done = 1'b1;
        tick; tick;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/seg7_scan_counter.md
SEG7_SCAN_COUNTER -- requirements
Module: seg7_scan_counter

Interface
REQ-001 Parameter DIGITS, default 4, sets the number of BCD digits and 7-segment positions (1..8).
REQ-002 Parameter SCAN_DIV, default 1000, sets the clock cycles each digit is driven per scan slot (>=2).
REQ-003 Parameter BLANK_LEADING, default 1, enables leading-zero blanking when 1.
REQ-004 clk  in  1  single system clock; all state changes on its rising edge.
REQ-005 rst_n  in  1  asynchronous, active-low reset.
REQ-006 en  in  1  count enable; one step per clock while high.
REQ-007 up  in  1  direction: 1 = increment, 0 = decrement.
REQ-008 clr  in  1  synchronous clear of the count to all zeros.
REQ-009 load  in  1  synchronous load of load_val.
REQ-010 load_val  in  4*DIGITS  BCD value to load; nibble 0 is the least significant digit.
REQ-011 bcd  out  4*DIGITS  current registered count, BCD.
REQ-012 carry  out  1  one-cycle pulse on wrap in either direction.
REQ-013 seg  out  7  segment drive {g,f,e,d,c,b,a}, active-low (0 = lit).
REQ-014 an  out  DIGITS  digit select, active-low, one-hot-low.

Function
REQ-015 Count priority per clock SHALL be clr > load > en; with none asserted, the count SHALL hold.
REQ-016 Increment SHALL be decimal per digit: 9 -> 0 with carry into the next digit; all-9s -> all-0s SHALL assert carry for exactly the next cycle.
REQ-017 Decrement SHALL be decimal per digit: 0 -> 9 with borrow from the next digit; all-0s -> all-9s SHALL assert carry for exactly the next cycle.
REQ-018 carry SHALL be registered, high only in the cycle after the wrapping edge, and never asserted by clr or load.
REQ-019 load SHALL force any load_val nibble greater than 9 to 0; valid nibbles SHALL be stored unchanged.
REQ-020 The count change SHALL be visible on bcd one cycle after the enabling edge; latency is 1.
REQ-021 A prescaler SHALL count 0..SCAN_DIV-1; at terminal count it SHALL return to 0 and advance the digit index by 1 modulo DIGITS.
REQ-022 an SHALL drive only bit [index] low; seg SHALL show the decode of digit [index] in the same cycle an changes, with both registered.
REQ-023 Decode for digits 0-9 SHALL use standard segments, e.g. 0 = 1000000, 1 = 1111001, 8 = 0000000, 9 = 0010000 ({g..a}, active-low).
REQ-024 When BLANK_LEADING = 1, a digit at index > 0 SHALL be blanked (seg = 1111111) if it and all higher digits are 0; digit 0 SHALL never be blanked.
REQ-025 The scan SHALL run continuously, independent of en, clr and load.
REQ-026 With DIGITS = 1, the index SHALL stay 0 and an SHALL be constant 0.

Reset
REQ-027 While rst_n is low, regardless of clk: count = 0, carry = 0, prescaler = 0, index = 0, an = all-ones except bit 0 low, seg = 1000000.
REQ-028 Reset asserted mid-count or mid-scan SHALL discard all state, and counting and scanning SHALL restart from the REQ-027 state on the first clock after deassertion.

Structure
REQ-029 Segment patterns, the blank constant and the BCD digit width (4) SHALL live in the shared package seg7_pkg.
REQ-030 The digit-to-segment decode SHALL be the combinational sub-module seg7_dec (4-bit in, 7-bit active-low out; 10-15 give blank), instantiated once on the selected digit.
REQ-031 Per-digit BCD increment and decrement SHALL be generated with a loop over DIGITS, with no hard-coded digit count.

Verification
REQ-032 Reset, then en = 1, up = 1 from 0000 for 10000 clocks -> bcd = 0000 again with exactly one carry pulse, in the cycle after 9999 -> 0000.
REQ-033 Load 0000, then en = 1, up = 0 for one clock -> bcd = 9999 and carry high for exactly one cycle.
REQ-034 load_val = 0x1A3F with load = 1 -> bcd = 0x1030; clr and load asserted together -> bcd = 0000.
REQ-035 SCAN_DIV = 4, bcd = 0042 -> an cycles 1110, 1101, 1011, 0111 every 4 clocks; seg = 0100100 (2), then 0011001 (4), then 1111111 (blank), then 1111111 (blank).
REQ-036 rst_n pulsed low between clock edges mid-scan with bcd = 0537 -> outputs take the REQ-027 values immediately, without waiting for a clock edge, and bcd = 0000.
REQ-037 BLANK_LEADING = 0, bcd = 0007 -> all four digits shown: 1000000, 1000000, 1000000, 1111000.
